// File: rtl/demod_stream_arbiter.sv
// ============================================================================
// demod_stream_arbiter
// ----------------------------------------------------------------------------
// Round-robin, packet-locked N:1 AXI-Stream arbiter in front of the shared
// demodulate pipeline. NUM_CH tuned-channel IQ/angle streams time-share one
// demodulator. Every output beat is tagged on m00_axis_tuser with the channel
// it came from, so downstream logic can keep per-channel angle history.
//
// A grant is held until the granted channel delivers tlast, or until
// BURST_MAX beats have been forwarded. In the BURST_MAX case tlast is forced
// on the last beat of the burst. Re-arbitration costs one idle input cycle.
//
// Ports
//   s00_axis_aclk     : sole clock
//   s00_axis_aresetn  : synchronous reset, active HIGH despite its name
//   s00_axis_tvalid   : per-channel valid, bit i = channel i
//   s00_axis_tdata    : channel i at [i*DW +: DW]
//   s00_axis_tlast    : per-channel end of packet
//   s00_axis_tstrb    : channel i at [i*DW/8 +: DW/8]
//   s00_axis_tready   : per-channel ready, only the granted bit can be 1
//   m00_axis_tready   : downstream ready
//   m00_axis_tvalid   : registered output valid
//   m00_axis_tdata    : registered forwarded data
//   m00_axis_tlast    : source tlast, or forced on the BURST_MAX-th beat
//   m00_axis_tstrb    : registered forwarded strobe
//   m00_axis_tuser    : source channel ID of the current output beat
//   stat_beats        : per-channel accepted-beat counters, 32 bits each
//
// Build option
//   ARB_STATS_EN : when defined, stat_beats[i*32 +: 32] counts accepted beats
//                  of channel i (wrapping, cleared by reset only). When not
//                  defined, stat_beats is tied to zero and no counters exist.
// ============================================================================
module demod_stream_arbiter #(
    parameter int NUM_CH                 = 4,
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int BURST_MAX              = 64
) (
    input  logic                                      s00_axis_aclk,
    input  logic                                      s00_axis_aresetn,
    input  logic [NUM_CH-1:0]                         s00_axis_tvalid,
    input  logic [NUM_CH*C_S00_AXIS_TDATA_WIDTH-1:0]  s00_axis_tdata,
    input  logic [NUM_CH-1:0]                         s00_axis_tlast,
    input  logic [NUM_CH*(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
    output logic [NUM_CH-1:0]                         s00_axis_tready,
    input  logic                                      m00_axis_tready,
    output logic                                      m00_axis_tvalid,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]         m00_axis_tdata,
    output logic                                      m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]       m00_axis_tstrb,
    output logic [$clog2(NUM_CH)-1:0]                 m00_axis_tuser,
    output logic [NUM_CH*32-1:0]                      stat_beats
);

    localparam int DW    = C_S00_AXIS_TDATA_WIDTH;
    localparam int SW    = DW / 8;
    localparam int ID_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // The reset input is active high even though it carries an AXI-style name.
    logic              rst_s;

    state_t            state_r;
    state_t            state_next_s;
    logic [ID_W-1:0]   grant_r;
    logic [ID_W-1:0]   rr_r;
    logic [CNT_W-1:0]  cnt_r;

    logic              m_valid_r;
    logic [DW-1:0]     m_data_r;
    logic              m_last_r;
    logic [SW-1:0]     m_strb_r;
    logic [ID_W-1:0]   m_user_r;

    logic              pick_found_s;
    logic [ID_W-1:0]   pick_s;
    logic              slot_free_s;
    logic              accept_s;
    logic              out_last_s;
    logic [DW-1:0]     sel_data_s;
    logic [SW-1:0]     sel_strb_s;

    assign rst_s = s00_axis_aresetn;

    // Output slot can take a beat when empty or being drained this cycle.
    assign slot_free_s = m00_axis_tready | ~m_valid_r;

    // Source mux for the granted channel.
    assign sel_data_s = s00_axis_tdata[int'(grant_r)*DW +: DW];
    assign sel_strb_s = s00_axis_tstrb[int'(grant_r)*SW +: SW];

    // Round-robin search: first requester after the last winner, wrapping.
    always_comb begin
        int sum_v;
        pick_found_s = 1'b0;
        pick_s       = '0;
        sum_v        = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            sum_v = int'(rr_r) + k;
            if (sum_v >= NUM_CH) begin
                sum_v = sum_v - NUM_CH;
            end else begin
                sum_v = sum_v;
            end
            if (!pick_found_s && s00_axis_tvalid[sum_v[ID_W-1:0]]) begin
                pick_found_s = 1'b1;
                pick_s       = sum_v[ID_W-1:0];
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Ready is offered only to the granted channel, and never during reset.
    always_comb begin
        s00_axis_tready = '0;
        if ((state_r == ST_GRANT) && !rst_s) begin
            s00_axis_tready[grant_r] = slot_free_s;
        end else begin
            s00_axis_tready = '0;
        end
    end

    // Beat acceptance and the forced end-of-burst marker.
    always_comb begin
        accept_s   = 1'b0;
        out_last_s = 1'b0;
        if (state_r == ST_GRANT) begin
            accept_s   = s00_axis_tvalid[grant_r] & slot_free_s & ~rst_s;
            out_last_s = s00_axis_tlast[grant_r] | (cnt_r == CNT_W'(BURST_MAX - 1));
        end else begin
            accept_s   = 1'b0;
            out_last_s = 1'b0;
        end
    end

    // Next-state logic for the arbiter FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_next_s = ST_GRANT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (accept_s && out_last_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_GRANT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, grant bookkeeping and burst counter.
    always_ff @(posedge s00_axis_aclk) begin
        if (rst_s) begin
            state_r <= ST_IDLE;
            grant_r <= '0;
            rr_r    <= ID_W'(NUM_CH - 1);
            cnt_r   <= '0;
        end else begin
            state_r <= state_next_s;
            if ((state_r == ST_IDLE) && pick_found_s) begin
                grant_r <= pick_s;
                rr_r    <= pick_s;
                cnt_r   <= '0;
            end else if (accept_s) begin
                cnt_r   <= cnt_r + CNT_W'(1);
            end
        end
    end

    // Registered output slot: load on accept, clear when drained with no refill.
    always_ff @(posedge s00_axis_aclk) begin
        if (rst_s) begin
            m_valid_r <= 1'b0;
            m_data_r  <= '0;
            m_last_r  <= 1'b0;
            m_strb_r  <= '0;
            m_user_r  <= '0;
        end else if (accept_s) begin
            m_valid_r <= 1'b1;
            m_data_r  <= sel_data_s;
            m_last_r  <= out_last_s;
            m_strb_r  <= sel_strb_s;
            m_user_r  <= grant_r;
        end else if (m_valid_r && m00_axis_tready) begin
            m_valid_r <= 1'b0;
        end
    end

    assign m00_axis_tvalid = m_valid_r;
    assign m00_axis_tdata  = m_data_r;
    assign m00_axis_tlast  = m_last_r;
    assign m00_axis_tstrb  = m_strb_r;
    assign m00_axis_tuser  = m_user_r;

`ifdef ARB_STATS_EN
    logic [31:0] stat_r [NUM_CH];

    // Per-channel accepted-beat counters, wrapping, cleared by reset only.
    always_ff @(posedge s00_axis_aclk) begin
        if (rst_s) begin
            for (int i = 0; i < NUM_CH; i++) begin
                stat_r[i] <= 32'd0;
            end
        end else if (accept_s) begin
            stat_r[grant_r] <= stat_r[grant_r] + 32'd1;
        end
    end

    // Flatten the counters onto the output bus.
    always_comb begin
        stat_beats = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            stat_beats[i*32 +: 32] = stat_r[i];
        end
    end
`else
    assign stat_beats = '0;
`endif

endmodule

// File: tb/tb_demod_stream_arbiter.sv
module tb_demod_stream_arbiter;

    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int BM  = 4;

    logic               clk;
    logic               rst;
    logic [NCH-1:0]     s_tvalid;
    logic [NCH*DW-1:0]  s_tdata;
    logic [NCH-1:0]     s_tlast;
    logic [NCH*4-1:0]   s_tstrb;
    logic [NCH-1:0]     s_tready;
    logic               m_tready;
    logic               m_tvalid;
    logic [DW-1:0]      m_tdata;
    logic               m_tlast;
    logic [3:0]         m_tstrb;
    logic [1:0]         m_tuser;
    logic [NCH*32-1:0]  stat_beats;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [1:0]  user;
        logic [3:0]  strb;
    } beat_t;

    beat_t exp_q[$];
    int    out_cyc[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc   = 0;

    demod_stream_arbiter #(
        .NUM_CH(NCH),
        .C_S00_AXIS_TDATA_WIDTH(DW),
        .C_M00_AXIS_TDATA_WIDTH(DW),
        .BURST_MAX(BM)
    ) dut (
        .s00_axis_aclk(clk),
        .s00_axis_aresetn(rst),
        .s00_axis_tvalid(s_tvalid),
        .s00_axis_tdata(s_tdata),
        .s00_axis_tlast(s_tlast),
        .s00_axis_tstrb(s_tstrb),
        .s00_axis_tready(s_tready),
        .m00_axis_tready(m_tready),
        .m00_axis_tvalid(m_tvalid),
        .m00_axis_tdata(m_tdata),
        .m00_axis_tlast(m_tlast),
        .m00_axis_tstrb(m_tstrb),
        .m00_axis_tuser(m_tuser),
        .stat_beats(stat_beats)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    function automatic logic [3:0] strb_of(input int ch, input int j);
        int v;
        v = ch * 5 + j * 3 + 1;
        return v[3:0];
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_beat(input int ch, input logic [31:0] data, input logic last, input int j);
        beat_t b;
        b.data = data;
        b.last = last;
        b.user = ch[1:0];
        b.strb = strb_of(ch, j);
        exp_q.push_back(b);
    endtask

    // Beats j0..j0+n-1 of a channel stream whose packets are pl beats long.
    task automatic push_range(input int ch, input logic [31:0] base, input int j0, input int n, input int pl);
        for (int j = j0; j < j0 + n; j++) begin
            push_beat(ch, base + 32'(j), ((j + 1) % pl) == 0, j);
        end
    endtask

    task automatic drive_ch(input int ch, input int n, input int pl, input logic [31:0] base, input int delay);
        logic acc;
        int   w;
        repeat (delay) @(posedge clk);
        @(posedge clk);
        for (int j = 0; j < n; j++) begin
            #1;
            s_tvalid[ch]           = 1'b1;
            s_tdata[ch*DW +: DW]   = base + 32'(j);
            s_tlast[ch]            = (((j + 1) % pl) == 0) || (j == n - 1);
            s_tstrb[ch*4 +: 4]     = strb_of(ch, j);
            acc = 1'b0;
            w   = 0;
            while (!acc && w < 200) begin
                @(negedge clk);
                acc = s_tready[ch] && s_tvalid[ch];
                @(posedge clk);
                w++;
            end
            if (!acc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL drive_timeout: got no tready on ch%0d beat %0d expected acceptance", ch, j);
                j = n;
            end
        end
        #1;
        s_tvalid[ch] = 1'b0;
        s_tlast[ch]  = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d beats outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    // Monitor: pops the scoreboard on every output handshake, checks stalls.
    initial begin
        beat_t a;
        beat_t e;
        beat_t prev;
        logic  prev_stall;
        prev_stall = 1'b0;
        prev       = '0;
        forever begin
            @(negedge clk);
            a = {m_tdata, m_tlast, m_tuser, m_tstrb};
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 128'(m_tvalid), 128'd1);
                    chk("hold_beat", 128'(a), 128'(prev));
                end
                if (m_tvalid && !m_tready) begin
                    chk("stall_s_tready", 128'(s_tready), 128'd0);
                end
                if (m_tvalid && m_tready) begin
                    out_cyc.push_back(cyc);
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_beat: got data=%h user=%0d expected none", a.data, a.user);
                    end else begin
                        e = exp_q.pop_front();
                        if (a !== e) begin
                            n_bad++;
                            $display("FAIL beat: got data=%h last=%b user=%0d strb=%h expected data=%h last=%b user=%0d strb=%h",
                                     a.data, a.last, a.user, a.strb, e.data, e.last, e.user, e.strb);
                        end
                    end
                end
                prev_stall = m_tvalid && !m_tready;
                prev       = a;
            end
        end
    end

    initial begin
        logic [31:0] st_exp [NCH];
        int          pat [6];
        pat = '{1, 0, 0, 1, 1, 0};

        rst      = 1'b1;
        m_tready = 1'b0;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        s_tstrb  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_tvalid", 128'(m_tvalid), 128'd0);
        chk("rst_m_tdata", 128'(m_tdata), 128'd0);
        chk("rst_m_tlast", 128'(m_tlast), 128'd0);
        chk("rst_m_tuser", 128'(m_tuser), 128'd0);
        chk("rst_m_tstrb", 128'(m_tstrb), 128'd0);
        chk("rst_s_tready", 128'(s_tready), 128'd0);
        chk("rst_stat", 128'(stat_beats), 128'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        m_tready = 1'b1;

        // Test 1: all four channels, 3-beat packets, round-robin from ch0.
        out_cyc.delete();
        for (int ch = 0; ch < NCH; ch++) begin
            push_range(ch, 32'hC000 + 32'(ch * 256), 0, 3, 3);
        end
        fork
            drive_ch(0, 3, 3, 32'hC000, 0);
            drive_ch(1, 3, 3, 32'hC100, 0);
            drive_ch(2, 3, 3, 32'hC200, 0);
            drive_ch(3, 3, 3, 32'hC300, 0);
        join
        drain();
        if (out_cyc.size() >= 12) begin
            for (int k = 0; k < 4; k++) begin
                chk("t1_b1_spacing", 128'(out_cyc[k*3+1] - out_cyc[k*3]), 128'd1);
                chk("t1_b2_spacing", 128'(out_cyc[k*3+2] - out_cyc[k*3+1]), 128'd1);
            end
            for (int k = 0; k < 3; k++) begin
                chk("t1_packet_gap", 128'(out_cyc[k*3+3] - out_cyc[k*3+2]), 128'd2);
            end
        end else begin
            chk("t1_beat_count", 128'(out_cyc.size()), 128'd12);
        end

        // Test 2: ch2 alone, 5-beat packet split by BURST_MAX=4.
        push_beat(2, 32'hD200, 1'b0, 0);
        push_beat(2, 32'hD201, 1'b0, 1);
        push_beat(2, 32'hD202, 1'b0, 2);
        push_beat(2, 32'hD203, 1'b1, 3);
        push_beat(2, 32'hD204, 1'b1, 4);
        drive_ch(2, 5, 5, 32'hD200, 0);
        drain();

        // Test 6: beat statistics after tests 1 and 2.
`ifdef ARB_STATS_EN
        st_exp = '{32'd3, 32'd3, 32'd8, 32'd3};
`else
        st_exp = '{32'd0, 32'd0, 32'd0, 32'd0};
`endif
        for (int ch = 0; ch < NCH; ch++) begin
            chk("stat_beats", 128'(stat_beats[ch*32 +: 32]), 128'(st_exp[ch]));
        end

        // Test 3: ch1 packet with downstream backpressure toggling.
        push_range(1, 32'hE100, 0, 4, 4);
        fork
            drive_ch(1, 4, 4, 32'hE100, 0);
            begin
                for (int i = 0; i < 24; i++) begin
                    @(posedge clk);
                    #1;
                    m_tready = (pat[i % 6] != 0);
                end
            end
        join
        #1;
        m_tready = 1'b1;
        drain();

        // Test 4: ch3 granted first, ch0 joins; grants must alternate.
        push_range(3, 32'hA300, 0, 3, 3);
        push_range(0, 32'hA000, 0, 3, 3);
        push_range(3, 32'hA300, 3, 3, 3);
        push_range(0, 32'hA000, 3, 3, 3);
        fork
            drive_ch(3, 6, 3, 32'hA300, 0);
            drive_ch(0, 6, 3, 32'hA000, 2);
        join
        drain();

        // Test 5: reset while a ch1 beat sits stalled in the output register.
        @(posedge clk);
        #1;
        m_tready          = 1'b0;
        s_tvalid[1]       = 1'b1;
        s_tdata[DW +: DW] = 32'hF100;
        s_tlast[1]        = 1'b0;
        s_tstrb[4 +: 4]   = 4'h5;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("t5_pre_valid", 128'(m_tvalid), 128'd1);
        chk("t5_pre_data", 128'(m_tdata), 128'hF100);
        chk("t5_pre_user", 128'(m_tuser), 128'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t5_rst_valid", 128'(m_tvalid), 128'd0);
        chk("t5_rst_data", 128'(m_tdata), 128'd0);
        chk("t5_rst_s_tready", 128'(s_tready), 128'd0);
        @(posedge clk);
        #1;
        s_tvalid[1] = 1'b0;
        rst         = 1'b0;
        m_tready    = 1'b1;
        push_range(1, 32'hB100, 0, 1, 1);
        push_range(3, 32'hB300, 0, 1, 1);
        fork
            drive_ch(1, 1, 1, 32'hB100, 0);
            drive_ch(3, 1, 1, 32'hB300, 0);
        join
        drain();

        chk("final_queue_empty", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
